csr_multi_start_ctrl: RTL and testbench
=======================================

# csr_multi_start_ctrl

Parametrised Avalon-MM CSR slave that drives NUM_CH independent start channels into the video pipeline, with programmable start-pulse length, repeat (continuous) mode, busy/done tracking from the pipeline, sticky interrupt status, and an LED field. It is the control-plane endpoint between the HPS bridge and the pipeline stages, replacing the single-channel fixed-pulse CSR block.

## Interface
- ADDR_W, 8, CSR word-address width
- NUM_CH, 4, number of start channels (1..8)
- PULSE_W, 8, width of per-channel pulse-length register
- LED_W, 3, LED field width
- LED_RESET, 3'b010, LED reset value
- ID_VALUE, 32'h12345678, value of read-only ID register

- clock_sink_clk  in  1  clock
- reset_sink_reset  in  1  asynchronous, active-high reset
- csr_address  in  ADDR_W  word address
- csr_read  in  1  read strobe
- csr_write  in  1  write strobe
- csr_writedata  in  32  write data
- csr_readdata  out  32  read data, valid with csr_readdatavalid
- csr_readdatavalid  out  1  one-cycle read-valid pulse
- start_flag  out  NUM_CH  per-channel start to pipeline
- done_in  in  NUM_CH  per-channel single-cycle completion pulse
- led_flag  out  LED_W  LED drive
- irq  out  1  level interrupt

## Operation
- Global map: 0x00 ID (RO); 0x01 LED (RW, bits[LED_W-1:0]); 0x02 IRQ_STATUS (bit ch = done sticky of enabled channel, W1C); 0x03 IRQ_MASK (RW, NUM_CH bits).
- Channel ch at base 0x10+4·ch: +0 CTRL (bit0 START write-one pulse, reads 0; bit1 REPEAT RW); +1 PULSE_LEN (RW, PULSE_W bits; 0 treated as 1); +2 STATUS (RO: bit0 busy, bit1 start_flag, bits[31:16] run_count); +3 reserved (reads 0).
- Unmapped or reserved addresses: writes ignored, reads return 0. Writes take effect from csr_writedata directly (no extra register stage).
- Per-channel FSM IDLE/PULSE/WAIT/REPEAT:
  - IDLE: START write -> PULSE, load counter = max(PULSE_LEN,1), busy=1. REPEAT=1 -> REPEAT.
  - PULSE: start_flag=1, counter decrements; at 1 -> WAIT (start_flag=0 next cycle).
  - WAIT: busy held until done_in -> IDLE.
  - REPEAT: start_flag=1 continuously, busy=1; REPEAT cleared -> IDLE, start_flag low next cycle.
- done_in in any state: run_count+1 (16-bit, wraps 0xFFFF->0), set IRQ_STATUS[ch], busy=0 unless in PULSE/REPEAT. done_in in IDLE counts and sets status.
- irq = |(IRQ_STATUS & IRQ_MASK), registered.
- Simultaneous events: START during PULSE reloads counter (restart); START during WAIT -> PULSE; done_in set and W1C clear same cycle -> set wins; REPEAT and START same write -> REPEAT.

## Timing
- Reset: start_flag=0, led_flag=LED_RESET, irq=0, csr_readdatavalid=0, csr_readdata=0, all registers 0, FSMs IDLE.
- Write at edge N -> start_flag high from N+1 for exactly PULSE_LEN cycles (1 if 0).
- Read: fixed latency 1; csr_readdatavalid high exactly one cycle after csr_read; csr_read and csr_write same cycle: write performed, read returns pre-write value.
- done_in at edge N -> IRQ_STATUS bit visible to a read at N+1, irq high at N+2.
- Reset mid-pulse: start_flag drops asynchronously.

## Structure
- Package csr_multi_start_pkg: address offsets (ID, LED, IRQ_STATUS, IRQ_MASK, channel base/stride, CTRL/PULSE_LEN/STATUS offsets), CTRL bit indices, FSM state enum.
- Sub-module csr_start_channel: per-channel FSM, pulse counter, run_count, busy; instantiated NUM_CH times via generate. Top holds decode, LED, IRQ regs, read mux.

## Test plan
- Reset then read 0x00 -> 0x12345678 one cycle later with readdatavalid; led_flag=3'b010; all start_flag=0.
- Ch0 PULSE_LEN=5, write CTRL=1 -> start_flag[0] high exactly 5 cycles; STATUS busy=1 until done_in[0], run_count=1.
- Ch1 PULSE_LEN=0, START -> 1-cycle pulse; START again during pulse of length 4 on ch2 -> pulse extends to 4 cycles after second write.
- Ch3 CTRL=2 -> start_flag[3] held high 100 cycles; write CTRL=0 -> low next cycle.
- IRQ_MASK=0x1, done_in[0] -> irq high 2 cycles later; W1C 0x1 with simultaneous done_in[0] -> bit stays set; plain W1C -> irq low.
- Preload run_count to 0xFFFF via 65535 done pulses, one more -> reads 0; read 0x13 and 0x7F -> 0.

Source files
------------

// File: rtl/csr_multi_start_ctrl_pkg.sv
// csr_multi_start_pkg: CSR address map, CTRL bit positions and channel FSM states
package csr_multi_start_pkg;
   localparam int ADDR_ID         = 'h00;
   localparam int ADDR_LED        = 'h01;
   localparam int ADDR_IRQ_STATUS = 'h02;
   localparam int ADDR_IRQ_MASK   = 'h03;
   localparam int CH_BASE         = 'h10;
   localparam int CH_STRIDE       = 4;
   localparam int OFF_CTRL        = 0;
   localparam int OFF_PULSE_LEN   = 1;
   localparam int OFF_STATUS      = 2;
   localparam int CTRL_START      = 0;
   localparam int CTRL_REPEAT     = 1;
   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT, ST_REPEAT} ch_state_t;
endpackage

// File: rtl/csr_start_channel.sv
// csr_start_channel: one start channel with pulse/repeat FSM, busy tracking and run counter
module csr_start_channel
   import csr_multi_start_pkg::*;
#(
   parameter int PULSE_W = 8
) (
   input  logic               clock_sink_clk,
   input  logic               reset_sink_reset,
   input  logic               ctrl_we,
   input  logic               len_we,
   input  logic [1:0]         ctrl_data,
   input  logic [PULSE_W-1:0] len_data,
   input  logic               done,
   output logic               start_flag,
   output logic               busy,
   output logic               rep,
   output logic [PULSE_W-1:0] pulse_len,
   output logic [15:0]        run_count
);
   ch_state_t          state;
   logic [PULSE_W-1:0] cnt;
   logic               start;
   logic               rep_next;
   logic [PULSE_W-1:0] load;
   assign start    = ctrl_we & ctrl_data[CTRL_START];
   assign rep_next = ctrl_we ? ctrl_data[CTRL_REPEAT] : rep;
   assign load     = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
   // Repeat outranks start so a combined write lands in continuous mode
   always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
      if (reset_sink_reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         start_flag <= 1'b0;
         busy       <= 1'b0;
         rep        <= 1'b0;
         pulse_len  <= '0;
         run_count  <= '0;
      end else begin
         if (ctrl_we) rep <= ctrl_data[CTRL_REPEAT];
         if (len_we) pulse_len <= len_data;
         if (done) run_count <= run_count + 16'd1;
         if (rep_next) begin
            state      <= ST_REPEAT;
            start_flag <= 1'b1;
            busy       <= 1'b1;
         end else if (start) begin
            state      <= ST_PULSE;
            cnt        <= load;
            start_flag <= 1'b1;
            busy       <= 1'b1;
         end else begin
            case (state)
               ST_PULSE:
                  if (cnt <= PULSE_W'(1)) begin
                     state      <= ST_WAIT;
                     start_flag <= 1'b0;
                  end else cnt <= cnt - PULSE_W'(1);
               ST_WAIT:
                  if (done) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               ST_REPEAT: begin
                  state      <= ST_IDLE;
                  start_flag <= 1'b0;
                  busy       <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: rtl/csr_multi_start_ctrl.sv
// csr_multi_start_ctrl: Avalon-MM CSR slave driving NUM_CH start channels with sticky done interrupts
module csr_multi_start_ctrl
   import csr_multi_start_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                NUM_CH    = 4,
   parameter int                PULSE_W   = 8,
   parameter int                LED_W     = 3,
   parameter logic [LED_W-1:0]  LED_RESET = 3'b010,
   parameter logic [31:0]       ID_VALUE  = 32'h12345678
) (
   input  logic              clock_sink_clk,
   input  logic              reset_sink_reset,
   input  logic [ADDR_W-1:0] csr_address,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic              csr_readdatavalid,
   output logic [NUM_CH-1:0] start_flag,
   input  logic [NUM_CH-1:0] done_in,
   output logic [LED_W-1:0]  led_flag,
   output logic              irq
);
   logic [NUM_CH-1:0]  irq_status;
   logic [NUM_CH-1:0]  irq_mask;
   logic [NUM_CH-1:0]  busy;
   logic [NUM_CH-1:0]  rep;
   logic [PULSE_W-1:0] pulse_len [NUM_CH];
   logic [15:0]        run_count [NUM_CH];
   logic [31:0]        ch_rd [NUM_CH];
   logic [31:0]        rd;
   logic [1:0]         off;
   logic               unused_wdata;
   assign off          = csr_address[1:0];
   assign unused_wdata = &{1'b0, csr_writedata};
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CH_BASE + CH_STRIDE * i);
      logic hit;
      assign hit = csr_address[ADDR_W-1:2] == BASE[ADDR_W-1:2];
      csr_start_channel #(.PULSE_W(PULSE_W)) u_ch (
         .clock_sink_clk  (clock_sink_clk),
         .reset_sink_reset(reset_sink_reset),
         .ctrl_we         (csr_write && hit && off == 2'(OFF_CTRL)),
         .len_we          (csr_write && hit && off == 2'(OFF_PULSE_LEN)),
         .ctrl_data       (csr_writedata[1:0]),
         .len_data        (csr_writedata[PULSE_W-1:0]),
         .done            (done_in[i]),
         .start_flag      (start_flag[i]),
         .busy            (busy[i]),
         .rep             (rep[i]),
         .pulse_len       (pulse_len[i]),
         .run_count       (run_count[i])
      );
      assign ch_rd[i] = !hit                        ? '0 :
                        off == 2'(OFF_CTRL)        ? {30'd0, rep[i], 1'b0} :
                        off == 2'(OFF_PULSE_LEN)   ? 32'(pulse_len[i]) :
                        off == 2'(OFF_STATUS)      ? {run_count[i], 14'd0, start_flag[i], busy[i]} : '0;
   end
   // Channel windows never overlap the global registers, so their words can simply be OR-ed in
   always_comb begin
      rd = csr_address == ADDR_W'(ADDR_ID)         ? ID_VALUE :
           csr_address == ADDR_W'(ADDR_LED)        ? 32'(led_flag) :
           csr_address == ADDR_W'(ADDR_IRQ_STATUS) ? 32'(irq_status) :
           csr_address == ADDR_W'(ADDR_IRQ_MASK)   ? 32'(irq_mask) : '0;
      for (int c = 0; c < NUM_CH; c++) rd = rd | ch_rd[c];
   end
   always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
      if (reset_sink_reset) begin
         led_flag          <= LED_RESET;
         irq_mask          <= '0;
         irq_status        <= '0;
         irq               <= 1'b0;
         csr_readdata      <= '0;
         csr_readdatavalid <= 1'b0;
      end else begin
         if (csr_write && csr_address == ADDR_W'(ADDR_LED)) led_flag <= csr_writedata[LED_W-1:0];
         if (csr_write && csr_address == ADDR_W'(ADDR_IRQ_MASK)) irq_mask <= csr_writedata[NUM_CH-1:0];
         irq_status <= (irq_status & ~((csr_write && csr_address == ADDR_W'(ADDR_IRQ_STATUS)) ?
                        csr_writedata[NUM_CH-1:0] : '0)) | done_in;
         irq               <= |(irq_status & irq_mask);
         csr_readdatavalid <= csr_read;
         if (csr_read) csr_readdata <= rd;
      end
   end
endmodule

// File: tb/tb_csr_multi_start_ctrl.sv
// tb_csr_multi_start_ctrl: directed vector table plus hand sequences for pulses, repeat, irq and wrap
module tb_csr_multi_start_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  addr = '0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic [3:0]  start_flag;
   logic [3:0]  done_in = '0;
   logic [2:0]  led_flag;
   logic        irq;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [16];

   csr_multi_start_ctrl dut (
      .clock_sink_clk   (clk),
      .reset_sink_reset (rst),
      .csr_address      (addr),
      .csr_read         (rd_en),
      .csr_write        (wr_en),
      .csr_writedata    (wdata),
      .csr_readdata     (rdata),
      .csr_readdatavalid(rvalid),
      .start_flag       (start_flag),
      .done_in          (done_in),
      .led_flag         (led_flag),
      .irq              (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
      addr  = a;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({name, "_valid"}, 32'(rvalid), 32'd1);
      chk(name, rdata, exp);
   endtask

   task automatic count_high(input int ch, input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         if (start_flag[ch]) n++;
         tick();
      end
   endtask

   initial begin
      int n;
      vt[0]  = '{1'b0, 8'h00, 32'h0,        32'h12345678};
      vt[1]  = '{1'b1, 8'h01, 32'h5,        32'h5};
      vt[2]  = '{1'b1, 8'h01, 32'hFFFFFFFF, 32'h7};
      vt[3]  = '{1'b1, 8'h03, 32'hFFFFFFF1, 32'h1};
      vt[4]  = '{1'b1, 8'h11, 32'h5,        32'h5};
      vt[5]  = '{1'b1, 8'h15, 32'h0,        32'h0};
      vt[6]  = '{1'b1, 8'h19, 32'h4,        32'h4};
      vt[7]  = '{1'b1, 8'h1D, 32'h1FF,      32'hFF};
      vt[8]  = '{1'b0, 8'h13, 32'h0,        32'h0};
      vt[9]  = '{1'b0, 8'h7F, 32'h0,        32'h0};
      vt[10] = '{1'b0, 8'h20, 32'h0,        32'h0};
      vt[11] = '{1'b0, 8'h04, 32'h0,        32'h0};
      vt[12] = '{1'b0, 8'h02, 32'h0,        32'h0};
      vt[13] = '{1'b0, 8'h12, 32'h0,        32'h0};
      vt[14] = '{1'b1, 8'h13, 32'hFFFF,     32'h0};
      vt[15] = '{1'b1, 8'h00, 32'h0,        32'h12345678};

      tick();
      tick();
      chk("rst_start", 32'(start_flag), 32'h0);
      chk("rst_led", 32'(led_flag), 32'h2);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      tick();

      rd(8'h00, 32'h12345678, "id");
      tick();
      chk("rvalid_drop", 32'(rvalid), 32'h0);

      for (int i = 0; i < 16; i++) begin
         if (vt[i].we) wr(vt[i].a, vt[i].wd);
         rd(vt[i].a, vt[i].exp, $sformatf("vec%0d", i));
      end
      chk("led_out", 32'(led_flag), 32'h7);

      // read and write in one cycle: old value returned, new value stored
      addr  = 8'h01;
      wdata = 32'h2;
      rd_en = 1'b1;
      wr_en = 1'b1;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      chk("rw_same_old", rdata, 32'h7);
      rd(8'h01, 32'h2, "rw_same_new");

      wr(8'h10, 32'h1);
      count_high(0, 20, n);
      chk("ch0_pulse_len5", 32'(n), 32'd5);
      rd(8'h12, 32'h1, "ch0_busy");
      done_in[0] = 1'b1;
      tick();
      done_in[0] = 1'b0;
      chk("irq_not_yet", 32'(irq), 32'h0);
      tick();
      chk("irq_high", 32'(irq), 32'h1);
      rd(8'h12, 32'h00010000, "ch0_done_status");
      rd(8'h02, 32'h1, "irq_status_set");

      addr       = 8'h02;
      wdata      = 32'h1;
      wr_en      = 1'b1;
      done_in[0] = 1'b1;
      tick();
      wr_en      = 1'b0;
      done_in[0] = 1'b0;
      rd(8'h02, 32'h1, "set_beats_w1c");
      chk("irq_held", 32'(irq), 32'h1);
      wr(8'h02, 32'h1);
      tick();
      chk("irq_cleared", 32'(irq), 32'h0);
      rd(8'h02, 32'h0, "irq_status_clr");

      wr(8'h14, 32'h1);
      count_high(1, 10, n);
      chk("ch1_len0_pulse", 32'(n), 32'd1);

      wr(8'h18, 32'h1);
      tick();
      tick();
      chk("ch2_first_high", 32'(start_flag[2]), 32'h1);
      wr(8'h18, 32'h1);
      count_high(2, 20, n);
      chk("ch2_restart", 32'(n), 32'd4);
      rd(8'h1A, 32'h1, "ch2_wait_busy");

      wr(8'h1C, 32'h2);
      count_high(3, 100, n);
      chk("ch3_repeat_100", 32'(n), 32'd100);
      rd(8'h1C, 32'h2, "ch3_ctrl_rb");
      rd(8'h1E, 32'h3, "ch3_status_rep");
      wr(8'h1C, 32'h0);
      chk("ch3_repeat_off", 32'(start_flag[3]), 32'h0);
      rd(8'h1E, 32'h0, "ch3_status_idle");

      done_in[1] = 1'b1;
      for (int k = 0; k < 65535; k++) tick();
      done_in[1] = 1'b0;
      rd(8'h16, 32'hFFFF0000, "ch1_count_max");
      done_in[1] = 1'b1;
      tick();
      done_in[1] = 1'b0;
      rd(8'h16, 32'h0, "ch1_count_wrap");
      chk("irq_masked", 32'(irq), 32'h0);
      rd(8'h13, 32'h0, "rsvd_13");
      rd(8'h7F, 32'h0, "unmapped_7f");

      wr(8'h10, 32'h1);
      tick();
      chk("pre_reset_high", 32'(start_flag[0]), 32'h1);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_flag", 32'(start_flag), 32'h0);
      chk("async_reset_led", 32'(led_flag), 32'h2);
      tick();
      rst = 1'b0;
      tick();
      rd(8'h11, 32'h0, "len_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
